// File: rtl/moore_masked_seq_det_param.sv
// Parametrised Moore serial sequence detector with per-bit don't-care mask.
// One serial bit is accepted per clock while En=1. The last PAT_LEN accepted bits form
// the history window CS (MSB = oldest). A match is flagged when the window is full and
// every cared-for bit equals PATTERN. OP is registered, so it is high for the cycle
// after the completing bit was sampled.
//
// Ports:
//   Clk    in   rising-edge clock
//   Rst    in   asynchronous active-low reset
//   In     in   serial data bit
//   En     in   sample enable
//   Ovl    in   1 = overlapping detection, 0 = non-overlapping
//   Clr    in   synchronous clear of Count/Sat (wins over a simultaneous match)
//   OP     out  registered detect pulse
//   Count  out  saturating match counter
//   Sat    out  sticky flag: Count reached all-ones
//   CS     out  history window
//   Fill   out  number of valid bits in the window, 0..PAT_LEN
module moore_masked_seq_det_param #(
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1000,
  parameter logic [PAT_LEN-1:0]   CARE    = 4'b1101,
  parameter int unsigned          CNT_W   = 8,
  localparam int unsigned         FILL_W  = $clog2(PAT_LEN + 1)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In,
  input  logic               En,
  input  logic               Ovl,
  input  logic               Clr,
  output logic               OP,
  output logic [CNT_W-1:0]   Count,
  output logic               Sat,
  output logic [PAT_LEN-1:0] CS,
  output logic [FILL_W-1:0]  Fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-1:0] cs_q, cs_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic               op_q, op_d;
  logic               match;

  // Window, fill and match detection. The compare uses the post-shift window so the
  // completing bit is included on the same edge it is sampled.
  always_comb begin
    cs_d     = cs_q;
    fill_d   = fill_q;
    fill_inc = fill_q;
    match    = 1'b0;
    if (En) begin
      cs_d     = {cs_q[PAT_LEN-2:0], In};
      fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
      match    = (fill_inc == FILL_FULL) && (((cs_d ^ PATTERN) & CARE) == '0);
      // Non-overlapping: discard the consumed bits by emptying the window count;
      // CS itself still shifts so the debug view stays a plain history.
      fill_d   = (match && !Ovl) ? '0 : fill_inc;
    end
    op_d = match;
  end

  // Saturating counter with sticky saturation flag; Clr has priority.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (Clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (match && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_W'(1);
      end
      sat_d = sat_q | (count_d == CNT_MAX);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cs_q    <= '0;
      fill_q  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      cs_q    <= cs_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      op_q    <= op_d;
    end
  end

  assign OP    = op_q;
  assign Count = count_q;
  assign Sat   = sat_q;
  assign CS    = cs_q;
  assign Fill  = fill_q;

endmodule

// File: tb/tb_moore_masked_seq_det_param.sv
// Bench for moore_masked_seq_det_param: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are compared every cycle against a bit-history reference model.
module tb_moore_masked_seq_det_param;

  localparam int unsigned L       = 4;
  localparam logic [3:0]  PAT     = 4'b1000;
  localparam logic [3:0]  CAREM   = 4'b1101;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       In, En, Ovl, Clr;
  logic       op_a, op_b;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic       sat_a, sat_b;
  logic [3:0] cs_a, cs_b;
  logic [2:0] fill_a, fill_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_cs;       // last L accepted bits as an integer
  int m_fill;     // bits accepted since reset / last non-overlapping match, capped at L
  int m_op;
  int m_matches;  // matches since reset / Clr, unbounded

  always #5 Clk = ~Clk;

  moore_masked_seq_det_param #(
    .PAT_LEN(L), .PATTERN(PAT), .CARE(CAREM), .CNT_W(8)
  ) u_a (
    .Clk(Clk), .Rst(Rst), .In(In), .En(En), .Ovl(Ovl), .Clr(Clr),
    .OP(op_a), .Count(count_a), .Sat(sat_a), .CS(cs_a), .Fill(fill_a)
  );

  moore_masked_seq_det_param #(
    .PAT_LEN(L), .PATTERN(PAT), .CARE(CAREM), .CNT_W(2)
  ) u_b (
    .Clk(Clk), .Rst(Rst), .In(In), .En(En), .Ovl(Ovl), .Clr(Clr),
    .OP(op_b), .Count(count_b), .Sat(sat_b), .CS(cs_b), .Fill(fill_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit window_matches(input int w);
    for (int i = 0; i < int'(L); i++) begin
      if (CAREM[i] && (((w >> i) & 1) != int'(PAT[i]))) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_cs = 0; m_fill = 0; m_op = 0; m_matches = 0;
  endtask

  task automatic model_edge(input logic in_b, input logic en_b, input logic ovl_b,
                            input logic clr_b);
    bit hit;
    hit = 1'b0;
    if (en_b) begin
      m_cs   = ((m_cs * 2) + int'(in_b)) % (1 << L);
      m_fill = min_i(m_fill + 1, L);
      hit    = (m_fill == int'(L)) && window_matches(m_cs);
      if (hit && !ovl_b) m_fill = 0;
    end
    m_op = int'(hit);
    if (clr_b) m_matches = 0;
    else if (hit) m_matches++;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".op"},     32'(op_a),    32'(m_op));
    check_eq({tag, ".cs"},     32'(cs_a),    32'(m_cs));
    check_eq({tag, ".fill"},   32'(fill_a),  32'(m_fill));
    check_eq({tag, ".count8"}, 32'(count_a), 32'(min_i(m_matches, 255)));
    check_eq({tag, ".sat8"},   32'(sat_a),   32'(m_matches >= 255));
    check_eq({tag, ".count2"}, 32'(count_b), 32'(min_i(m_matches, 3)));
    check_eq({tag, ".sat2"},   32'(sat_b),   32'(m_matches >= 3));
    check_eq({tag, ".op2"},    32'(op_b),    32'(m_op));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input string tag, input logic in_b, input logic en_b,
                      input logic ovl_b, input logic clr_b);
    In = in_b; En = en_b; Ovl = ovl_b; Clr = clr_b;
    @(posedge Clk);
    model_edge(in_b, en_b, ovl_b, clr_b);
    #1 compare_all(tag);
    @(negedge Clk);
  endtask

  task automatic feed4(input string tag, input logic [3:0] bits, input logic ovl_b);
    for (int i = 3; i >= 0; i--) step(tag, bits[i], 1'b1, ovl_b, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge arrives.
  task automatic async_reset(input string tag);
    En = 1'b0; Clr = 1'b0;
    #2 Rst = 1'b0;
    model_reset();
    #1;
    check_eq({tag, ".rst_op"},   32'(op_a),    32'd0);
    check_eq({tag, ".rst_cs"},   32'(cs_a),    32'd0);
    check_eq({tag, ".rst_fill"}, 32'(fill_a),  32'd0);
    check_eq({tag, ".rst_cnt"},  32'(count_a), 32'd0);
    check_eq({tag, ".rst_sat"},  32'(sat_a),   32'd0);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    logic ovl_r;
    Rst = 1'b0; In = 1'b0; En = 1'b0; Ovl = 1'b0; Clr = 1'b0;
    model_reset();
    #1 compare_all("por");
    @(negedge Clk);
    Rst = 1'b1;

    // 1: async reset mid-sequence, then a full fresh pattern is needed
    step("t1", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t1", 1'b0, 1'b1, 1'b1, 1'b0);
    step("t1", 1'b1, 1'b1, 1'b1, 1'b0);
    async_reset("t1");
    feed4("t1b", 4'b1000, 1'b1);
    check_eq("t1.op_after4", 32'(op_a), 32'd1);

    // 2: overlapping 101010 -> matches after bits 4 and 6
    async_reset("t2");
    feed4("t2", 4'b1010, 1'b1);
    step("t2", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t2", 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("t2.op_bit6", 32'(op_a),    32'd1);
    check_eq("t2.count",   32'(count_a), 32'd2);

    // 3: non-overlapping 101010 -> one match, Fill=2 at end
    async_reset("t3");
    feed4("t3", 4'b1010, 1'b0);
    step("t3", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t3", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t3.op_bit6", 32'(op_a),    32'd0);
    check_eq("t3.count",   32'(count_a), 32'd1);
    check_eq("t3.fill",    32'(fill_a),  32'd2);

    // 4: don't-care position
    async_reset("t4a"); feed4("t4a", 4'b1000, 1'b0); check_eq("t4a.op", 32'(op_a), 32'd1);
    async_reset("t4b"); feed4("t4b", 4'b1010, 1'b0); check_eq("t4b.op", 32'(op_a), 32'd1);
    async_reset("t4c"); feed4("t4c", 4'b1110, 1'b0); check_eq("t4c.op", 32'(op_a), 32'd0);
    async_reset("t4d"); feed4("t4d", 4'b0010, 1'b0); check_eq("t4d.op", 32'(op_a), 32'd0);

    // 5: enable gating
    async_reset("t5");
    step("t5", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t5", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("t5", logic'(i % 2), 1'b0, 1'b0, 1'b0);
      check_eq("t5.op_hold", 32'(op_a), 32'd0);
    end
    step("t5", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t5", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t5.op",    32'(op_a),    32'd1);
    check_eq("t5.count", 32'(count_a), 32'd1);

    // 6: 2-bit counter saturation, then Clr colliding with a match
    async_reset("t6");
    for (int i = 0; i < 4; i++) feed4("t6", 4'b1000, 1'b0);
    check_eq("t6.count2", 32'(count_b), 32'd3);
    check_eq("t6.sat2",   32'(sat_b),   32'd1);
    check_eq("t6.count8", 32'(count_a), 32'd4);
    step("t6c", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t6c", 1'b0, 1'b1, 1'b0, 1'b0);
    step("t6c", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t6c", 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("t6c.op",     32'(op_b),    32'd1);
    check_eq("t6c.count2", 32'(count_b), 32'd0);
    check_eq("t6c.sat2",   32'(sat_b),   32'd0);

    // Randomised stream against the model
    async_reset("rnd");
    ovl_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) ovl_r = ~ovl_r;
      if ($urandom_range(0, 299) == 0) async_reset("rnd");
      step("rnd", logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0), ovl_r,
           logic'($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
